// File: rtl/universal_shift_register.sv
// Universal shift register: hold / shift-left / shift-right / parallel load, with a frame counter.
// Latency: po/so/shift_cnt/frame_valid update on the same rising edge the command is sampled.
// Backpressure: none; en=0 freezes state (frame_valid drops), sync_clr overrides everything.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   clear_n      asynchronous reset, active-low
//   sync_clr     synchronous clear, highest synchronous priority
//   en           command enable (0 = hold)
//   mode         00 HOLD, 01 SHL, 10 SHR, 11 LOAD
//   si           serial in (LSB on SHL, MSB on SHR)
//   pi           parallel load data
//   rot          (only with ROTATE_EN) recirculate the outgoing bit instead of si
//   po           register contents
//   so           bit shifted out by the most recent shift
//   frame_valid  one-cycle pulse when WIDTH counted shifts complete a frame
//   shift_cnt    counted shifts in the current frame
//
// Optional feature macro: ROTATE_EN (adds the rot input).

module universal_shift_register #(
    parameter int               WIDTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             sync_clr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             si,
    input  logic [WIDTH-1:0] pi,
`ifdef ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] po,
    output logic             so,
    output logic             frame_valid,
    output logic [CW-1:0]    shift_cnt
);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic             rot_act;
    logic             shl_in;
    logic             shr_in;
    logic [WIDTH-1:0] po_nxt;
    logic             so_nxt;
    logic             fv_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             count_shift;

`ifdef ROTATE_EN
    assign rot_act = rot;
`else
    assign rot_act = 1'b0;
`endif

    // Rotation feeds the bit leaving the opposite end back in.
    assign shl_in = rot_act ? po[WIDTH-1] : si;
    assign shr_in = rot_act ? po[0]       : si;

    always_comb begin
        po_nxt      = po;
        so_nxt      = so;
        cnt_nxt     = shift_cnt;
        fv_nxt      = 1'b0;
        count_shift = 1'b0;

        if (sync_clr) begin
            po_nxt  = RESET_VAL;
            so_nxt  = 1'b0;
            cnt_nxt = '0;
        end else if (en) begin
            case (mode)
                MODE_SHL: begin
                    po_nxt      = {po[WIDTH-2:0], shl_in};
                    so_nxt      = po[WIDTH-1];
                    count_shift = !rot_act;
                end
                MODE_SHR: begin
                    po_nxt      = {shr_in, po[WIDTH-1:1]};
                    so_nxt      = po[0];
                    count_shift = !rot_act;
                end
                MODE_LOAD: begin
                    po_nxt  = pi;
                    cnt_nxt = '0;
                end
                MODE_HOLD: ;
                default: ;
            endcase

            // Only serial shift-ins build a frame; rotates leave the count alone.
            if (count_shift) begin
                if (shift_cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    fv_nxt  = 1'b1;
                end else begin
                    cnt_nxt = shift_cnt + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            po          <= RESET_VAL;
            so          <= 1'b0;
            frame_valid <= 1'b0;
            shift_cnt   <= '0;
        end else begin
            po          <= po_nxt;
            so          <= so_nxt;
            frame_valid <= fv_nxt;
            shift_cnt   <= cnt_nxt;
        end
    end

    // An unknown mode while enabled would silently corrupt state.
    mode_known_a: assert property (@(posedge clk) disable iff (!clear_n)
                                   (en && !sync_clr) |-> !$isunknown(mode));

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

    localparam int W  = 3;
    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] SHL  = 2'b01;
    localparam logic [1:0] SHR  = 2'b10;
    localparam logic [1:0] LOAD = 2'b11;

    logic          clk;
    logic          clear_n;
    logic          sync_clr;
    logic          en;
    logic [1:0]    mode;
    logic          si;
    logic [W-1:0]  pi;
`ifdef ROTATE_EN
    logic          rot;
`endif
    logic [W-1:0]  po;
    logic          so;
    logic          frame_valid;
    logic [CW-1:0] shift_cnt;

    universal_shift_register #(.WIDTH(W), .RESET_VAL(3'b000)) dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .sync_clr    (sync_clr),
        .en          (en),
        .mode        (mode),
        .si          (si),
        .pi          (pi),
`ifdef ROTATE_EN
        .rot         (rot),
`endif
        .po          (po),
        .so          (so),
        .frame_valid (frame_valid),
        .shift_cnt   (shift_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          sc;
        logic          e;
        logic [1:0]    m;
        logic          s;
        logic [W-1:0]  p;
        logic [W-1:0]  x_po;
        logic          x_so;
        logic          x_fv;
        logic [CW-1:0] x_cnt;
    } vec_t;

    vec_t vecs[19];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [W-1:0] x_po,
                           input logic x_so, input logic x_fv, input logic [CW-1:0] x_cnt);
        chk({tag, ".po"},  idx, 32'(po),          32'(x_po));
        chk({tag, ".so"},  idx, 32'(so),          32'(x_so));
        chk({tag, ".fv"},  idx, 32'(frame_valid), 32'(x_fv));
        chk({tag, ".cnt"}, idx, 32'(shift_cnt),   32'(x_cnt));
    endtask

    // Inputs change just after a falling edge; outputs are sampled on the next falling edge.
    task automatic drive(input logic sc, input logic e, input logic [1:0] m,
                         input logic s, input logic [W-1:0] p);
        sync_clr = sc; en = e; mode = m; si = s; pi = p;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //               sc e  mode  si pi      po      so  fv cnt
        vecs[0]  = '{1'b0,1'b1,LOAD,1'b0,3'b111, 3'b111,1'b0,1'b0,2'd0};
        vecs[1]  = '{1'b1,1'b1,LOAD,1'b0,3'b111, 3'b000,1'b0,1'b0,2'd0};
        vecs[2]  = '{1'b0,1'b1,SHL, 1'b1,3'b000, 3'b001,1'b0,1'b0,2'd1};
        vecs[3]  = '{1'b0,1'b1,SHL, 1'b0,3'b000, 3'b010,1'b0,1'b0,2'd2};
        vecs[4]  = '{1'b0,1'b1,SHL, 1'b1,3'b000, 3'b101,1'b0,1'b1,2'd0};
        vecs[5]  = '{1'b0,1'b1,SHL, 1'b1,3'b000, 3'b011,1'b1,1'b0,2'd1};
        vecs[6]  = '{1'b0,1'b0,SHL, 1'b0,3'b000, 3'b011,1'b1,1'b0,2'd1};
        vecs[7]  = '{1'b0,1'b1,HOLD,1'b0,3'b000, 3'b011,1'b1,1'b0,2'd1};
        vecs[8]  = '{1'b0,1'b1,LOAD,1'b0,3'b110, 3'b110,1'b1,1'b0,2'd0};
        vecs[9]  = '{1'b0,1'b1,SHR, 1'b0,3'b000, 3'b011,1'b0,1'b0,2'd1};
        vecs[10] = '{1'b0,1'b1,SHR, 1'b1,3'b000, 3'b101,1'b1,1'b0,2'd2};
        vecs[11] = '{1'b0,1'b1,SHL, 1'b0,3'b000, 3'b010,1'b1,1'b1,2'd0};
        vecs[12] = '{1'b1,1'b0,SHL, 1'b1,3'b111, 3'b000,1'b0,1'b0,2'd0};
        vecs[13] = '{1'b0,1'b1,SHR, 1'b1,3'b000, 3'b100,1'b0,1'b0,2'd1};
        vecs[14] = '{1'b1,1'b1,SHR, 1'b1,3'b000, 3'b000,1'b0,1'b0,2'd0};
        vecs[15] = '{1'b0,1'b1,SHR, 1'b1,3'b000, 3'b100,1'b0,1'b0,2'd1};
        vecs[16] = '{1'b0,1'b1,SHR, 1'b1,3'b000, 3'b110,1'b0,1'b0,2'd2};
        vecs[17] = '{1'b0,1'b1,SHR, 1'b0,3'b000, 3'b011,1'b0,1'b1,2'd0};
        vecs[18] = '{1'b0,1'b1,SHR, 1'b0,3'b000, 3'b001,1'b1,1'b0,2'd1};

        clear_n = 1'b0;
        drive(1'b0, 1'b0, HOLD, 1'b0, 3'b000);
`ifdef ROTATE_EN
        rot = 1'b0;
`endif
        #2;
        chk_all("reset", 0, 3'b000, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        clear_n = 1'b1;

        // Table-driven main function.
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].sc, vecs[i].e, vecs[i].m, vecs[i].s, vecs[i].p);
            step();
            chk_all("vec", i, vecs[i].x_po, vecs[i].x_so, vecs[i].x_fv, vecs[i].x_cnt);
        end

        // Async reset between edges takes effect with no clock.
        drive(1'b0, 1'b1, LOAD, 1'b0, 3'b101);
        step();
        chk("load101.po", 0, 32'(po), 32'(3'b101));
        drive(1'b0, 1'b0, HOLD, 1'b0, 3'b000);
        #1 clear_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 3'b000, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        clear_n = 1'b1;

        // Two shifts, a 3-cycle enable gap, then the frame-completing shift.
        drive(1'b0, 1'b1, SHL, 1'b1, 3'b000);
        step();
        chk_all("gap", 0, 3'b001, 1'b0, 1'b0, 2'd1);
        step();
        chk_all("gap", 1, 3'b011, 1'b0, 1'b0, 2'd2);
        drive(1'b0, 1'b0, SHL, 1'b0, 3'b000);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_all("gap_hold", k, 3'b011, 1'b0, 1'b0, 2'd2);
        end
        drive(1'b0, 1'b1, SHL, 1'b0, 3'b000);
        step();
        chk_all("gap", 2, 3'b110, 1'b0, 1'b1, 2'd0);
        drive(1'b0, 1'b1, HOLD, 1'b0, 3'b000);
        step();
        chk_all("gap", 3, 3'b110, 1'b0, 1'b0, 2'd0);

        // Reset mid-frame discards the partial count.
        drive(1'b0, 1'b1, SHL, 1'b1, 3'b000);
        step();
        step();
        chk("mid.cnt_pre", 0, 32'(shift_cnt), 32'(2));
        drive(1'b0, 1'b0, HOLD, 1'b0, 3'b000);
        clear_n = 1'b0;
        #1;
        chk_all("mid_rst", 0, 3'b000, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        clear_n = 1'b1;
        drive(1'b0, 1'b1, SHL, 1'b1, 3'b000);
        step();
        chk_all("mid_after", 0, 3'b001, 1'b0, 1'b0, 2'd1);

`ifdef ROTATE_EN
        // Rotates recirculate and do not count toward a frame.
        drive(1'b0, 1'b1, LOAD, 1'b0, 3'b100);
        step();
        chk_all("rot_load", 0, 3'b100, 1'b0, 1'b0, 2'd0);
        rot = 1'b1;
        drive(1'b0, 1'b1, SHL, 1'b0, 3'b000);
        step();
        chk_all("rot", 0, 3'b001, 1'b1, 1'b0, 2'd0);
        step();
        chk_all("rot", 1, 3'b010, 1'b0, 1'b0, 2'd0);
        step();
        chk_all("rot", 2, 3'b100, 1'b0, 1'b0, 2'd0);
        rot = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
